// File: rtl/rx_parity_engine.sv
// Bit-serial UART receive parity checker: accumulates data-bit parity, checks the
// parity bit against the latched mode, and flags sequencing errors.
module rx_parity_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 new_frame,
    input  logic                 parity_en,
    input  logic [1:0]           par_mode,
    input  logic                 bit_valid,
    input  logic                 par_valid,
    input  logic                 sampled_bit,
    input  logic                 cnt_clr,
    output logic                 parity_error,
    output logic                 seq_error,
    output logic                 par_done,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA     = 2'd1,
        WAIT_PAR = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 acc_q, acc_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 en_q, en_d;
    logic [1:0]           mode_q, mode_d;
    logic                 perr_d, serr_d, done_d;
    logic [CNT_WIDTH-1:0] err_count_d;
    logic                 mismatch;
    logic                 expected;

    always_comb begin
        unique case (mode_q)
            2'b00:   expected = acc_q;
            2'b01:   expected = ~acc_q;
            2'b10:   expected = 1'b1;
            default: expected = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        en_d      = en_q;
        mode_d    = mode_q;
        perr_d    = parity_error;
        serr_d    = seq_error;
        done_d    = 1'b0;
        mismatch  = 1'b0;

        if (new_frame) begin
            acc_d     = 1'b0;
            bit_cnt_d = '0;
            perr_d    = 1'b0;
            serr_d    = 1'b0;
            en_d      = parity_en;
            mode_d    = par_mode;
            state_d   = DATA;
        end else begin
            unique case (state_q)
                DATA: begin
                    if (par_valid) begin
                        serr_d  = 1'b1;
                        state_d = IDLE;
                    end else if (bit_valid) begin
                        acc_d     = acc_q ^ sampled_bit;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            if (en_q) begin
                                state_d = WAIT_PAR;
                            end else begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                WAIT_PAR: begin
                    // bit_valid here (alone or with par_valid) is an ordering fault
                    if (bit_valid) begin
                        serr_d  = 1'b1;
                        state_d = IDLE;
                    end else if (par_valid) begin
                        mismatch = (sampled_bit != expected);
                        perr_d   = mismatch;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        err_count_d = err_count;
        if (cnt_clr) begin
            err_count_d = '0;
        end else if (mismatch && (err_count != '1)) begin
            err_count_d = err_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            acc_q        <= 1'b0;
            bit_cnt_q    <= '0;
            en_q         <= 1'b0;
            mode_q       <= 2'b00;
            parity_error <= 1'b0;
            seq_error    <= 1'b0;
            par_done     <= 1'b0;
            err_count    <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            en_q         <= en_d;
            mode_q       <= mode_d;
            parity_error <= perr_d;
            seq_error    <= serr_d;
            par_done     <= done_d;
            err_count    <= err_count_d;
        end
    end

endmodule

// File: tb/tb_rx_parity_engine.sv
// Directed bench for rx_parity_engine: three instances (8/8, 8/2, 7/8) share the
// same stimulus; each scenario task checks the instance it targets.
module tb_rx_parity_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic new_frame = 1'b0, parity_en = 1'b0, bit_valid = 1'b0, par_valid = 1'b0;
    logic sampled_bit = 1'b0, cnt_clr = 1'b0;
    logic [1:0] par_mode = 2'b00;

    logic       a_perr, a_serr, a_done;
    logic [7:0] a_cnt;
    logic       b_perr, b_serr, b_done;
    logic [1:0] b_cnt;
    logic       c_perr, c_serr, c_done;
    logic [7:0] c_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    rx_parity_engine #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .new_frame(new_frame), .parity_en(parity_en),
        .par_mode(par_mode), .bit_valid(bit_valid), .par_valid(par_valid),
        .sampled_bit(sampled_bit), .cnt_clr(cnt_clr), .parity_error(a_perr),
        .seq_error(a_serr), .par_done(a_done), .err_count(a_cnt));

    rx_parity_engine #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .new_frame(new_frame), .parity_en(parity_en),
        .par_mode(par_mode), .bit_valid(bit_valid), .par_valid(par_valid),
        .sampled_bit(sampled_bit), .cnt_clr(cnt_clr), .parity_error(b_perr),
        .seq_error(b_serr), .par_done(b_done), .err_count(b_cnt));

    rx_parity_engine #(.DATA_WIDTH(7), .CNT_WIDTH(8)) dut_c (
        .clk(clk), .rst(rst), .new_frame(new_frame), .parity_en(parity_en),
        .par_mode(par_mode), .bit_valid(bit_valid), .par_valid(par_valid),
        .sampled_bit(sampled_bit), .cnt_clr(cnt_clr), .parity_error(c_perr),
        .seq_error(c_serr), .par_done(c_done), .err_count(c_cnt));

    // Drive one cycle of strobes at a falling edge; return at the next falling
    // edge, where the outputs reflect the rising edge that sampled them.
    task automatic cyc(input logic nf, input logic bv, input logic pv, input logic b);
        new_frame = nf; bit_valid = bv; par_valid = pv; sampled_bit = b;
        @(negedge clk);
        new_frame = 1'b0; bit_valid = 1'b0; par_valid = 1'b0; sampled_bit = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic start(input logic en, input logic [1:0] mode);
        parity_en = en; par_mode = mode;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input logic [8:0] data, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, data[i]);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        @(negedge clk); @(negedge clk);
        total_cnt++; if ({a_perr, a_serr, a_done, a_cnt} !== 11'd0) $display("FAIL reset_a got %b want 0", {a_perr, a_serr, a_done, a_cnt}); else pass_cnt++;
        total_cnt++; if ({b_perr, b_serr, b_done, b_cnt} !== 5'd0) $display("FAIL reset_b got %b want 0", {b_perr, b_serr, b_done, b_cnt}); else pass_cnt++;
        total_cnt++; if ({c_perr, c_serr, c_done, c_cnt} !== 11'd0) $display("FAIL reset_c got %b want 0", {c_perr, c_serr, c_done, c_cnt}); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_even;
        start(1'b1, 2'b00);
        send_bits(9'h0A5, 8);
        total_cnt++; if (a_done !== 1'b0) $display("FAIL even_early_done got %b want 0", a_done); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        total_cnt++; if (a_done !== 1'b1) $display("FAIL even_done got %b want 1", a_done); else pass_cnt++;
        total_cnt++; if (a_perr !== 1'b0) $display("FAIL even_perr got %b want 0", a_perr); else pass_cnt++;
        total_cnt++; if (a_cnt !== 8'd0) $display("FAIL even_cnt got %0d want 0", a_cnt); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (a_done !== 1'b0) $display("FAIL even_done_pulse got %b want 0", a_done); else pass_cnt++;
    endtask

    task automatic test_modes;
        start(1'b1, 2'b01);
        send_bits(9'h0A5, 8);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        total_cnt++; if (a_perr !== 1'b1) $display("FAIL odd_perr got %b want 1", a_perr); else pass_cnt++;
        total_cnt++; if (a_cnt !== 8'd1) $display("FAIL odd_cnt got %0d want 1", a_cnt); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (a_perr !== 1'b1) $display("FAIL odd_perr_sticky got %b want 1", a_perr); else pass_cnt++;
        start(1'b1, 2'b00);
        total_cnt++; if (a_perr !== 1'b0) $display("FAIL newframe_clr got %b want 0", a_perr); else pass_cnt++;
        start(1'b1, 2'b10);
        par_mode = 2'b11; // mid-frame change must not take effect
        send_bits(9'h0A5, 8);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        total_cnt++; if (a_perr !== 1'b1) $display("FAIL mark_perr got %b want 1", a_perr); else pass_cnt++;
        total_cnt++; if (a_cnt !== 8'd2) $display("FAIL mark_cnt got %0d want 2", a_cnt); else pass_cnt++;
        start(1'b1, 2'b11);
        send_bits(9'h0A5, 8);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        total_cnt++; if ({a_done, a_perr} !== 2'b10) $display("FAIL space_done_perr got %b want 10", {a_done, a_perr}); else pass_cnt++;
        total_cnt++; if (a_cnt !== 8'd2) $display("FAIL space_cnt got %0d want 2", a_cnt); else pass_cnt++;
    endtask

    task automatic test_no_parity;
        start(1'b0, 2'b00);
        send_bits(9'h0FF, 7);
        total_cnt++; if (a_done !== 1'b0) $display("FAIL nopar_early got %b want 0", a_done); else pass_cnt++;
        send_bits(9'h001, 1);
        total_cnt++; if ({a_done, a_perr} !== 2'b10) $display("FAIL nopar_done_perr got %b want 10", {a_done, a_perr}); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        total_cnt++; if ({a_done, a_perr, a_serr} !== 3'b000) $display("FAIL idle_parvalid got %b want 000", {a_done, a_perr, a_serr}); else pass_cnt++;
        total_cnt++; if (a_cnt !== 8'd2) $display("FAIL idle_cnt got %0d want 2", a_cnt); else pass_cnt++;
    endtask

    task automatic test_seq_error;
        start(1'b1, 2'b00);
        send_bits(9'h01F, 5);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        total_cnt++; if ({a_serr, a_done} !== 2'b10) $display("FAIL early_par got %b want 10", {a_serr, a_done}); else pass_cnt++;
        send_bits(9'h007, 3);
        total_cnt++; if ({a_serr, a_done} !== 2'b10) $display("FAIL seq_sticky got %b want 10", {a_serr, a_done}); else pass_cnt++;
        start(1'b1, 2'b00);
        total_cnt++; if (a_serr !== 1'b0) $display("FAIL seq_clr got %b want 0", a_serr); else pass_cnt++;
        send_bits(9'h000, 8);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        total_cnt++; if ({a_serr, a_done, a_perr} !== 3'b100) $display("FAIL both_strobes got %b want 100", {a_serr, a_done, a_perr}); else pass_cnt++;
    endtask

    task automatic test_saturation;
        cnt_clr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        total_cnt++; if ({a_cnt, b_cnt} !== 10'd0) $display("FAIL cnt_clr got %0d/%0d want 0/0", a_cnt, b_cnt); else pass_cnt++;
        for (int unsigned k = 1; k <= 5; k++) begin
            start(1'b1, 2'b01);
            send_bits(9'h0A5, 8);
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            total_cnt++; if (b_cnt !== 2'((k > 3) ? 3 : k)) $display("FAIL sat_b%0d got %0d want %0d", k, b_cnt, (k > 3) ? 3 : k); else pass_cnt++;
            total_cnt++; if (a_cnt !== 8'(k)) $display("FAIL sat_a%0d got %0d want %0d", k, a_cnt, k); else pass_cnt++;
        end
        start(1'b1, 2'b01);
        send_bits(9'h0A5, 8);
        cnt_clr = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        total_cnt++; if ({a_cnt, b_cnt} !== 10'd0) $display("FAIL clr_vs_inc got %0d/%0d want 0/0", a_cnt, b_cnt); else pass_cnt++;
        total_cnt++; if (a_perr !== 1'b1) $display("FAIL clr_vs_inc_perr got %b want 1", a_perr); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame;
        start(1'b1, 2'b00);
        send_bits(9'h00F, 4);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        total_cnt++; if ({a_done, a_perr, a_serr} !== 3'b000) $display("FAIL midrst_a got %b want 000", {a_done, a_perr, a_serr}); else pass_cnt++;
        send_bits(9'h00F, 4);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        total_cnt++; if ({a_done, a_serr} !== 2'b00) $display("FAIL midrst_abandon got %b want 00", {a_done, a_serr}); else pass_cnt++;
        start(1'b1, 2'b00);
        send_bits(9'h001, 8);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        total_cnt++; if ({a_done, a_perr} !== 2'b10) $display("FAIL post_rst_a got %b want 10", {a_done, a_perr}); else pass_cnt++;

        start(1'b1, 2'b00);
        send_bits(9'h00F, 4);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        total_cnt++; if ({c_done, c_perr, c_serr, c_cnt} !== 11'd0) $display("FAIL midrst_c got %b want 0", {c_done, c_perr, c_serr, c_cnt}); else pass_cnt++;
        start(1'b1, 2'b00);
        send_bits(9'h001, 6);
        total_cnt++; if (c_done !== 1'b0) $display("FAIL dw7_early got %b want 0", c_done); else pass_cnt++;
        send_bits(9'h000, 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        total_cnt++; if ({c_done, c_perr, c_serr} !== 3'b100) $display("FAIL dw7_frame got %b want 100", {c_done, c_perr, c_serr}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_even();
        test_modes();
        test_no_parity();
        test_seq_error();
        test_saturation();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
